router_fsm: RTL and testbench

Packet-sequencing controller for the 1x3 router. It watches the source handshake (`pkt_valid`, header address), the destination FIFO status and the parity checker. It then drives the register block and synchronizer through header decode, first-data load, payload load, FIFO-full stall, parity load and parity check. It sits between the input port and the register/synchronizer/FIFO datapath and is the only block that asserts `busy` back to the source.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_fsm.sv | 123 ++++++++++++
 tb/tb_router_fsm.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: packet-sequencing FSM states and
// header address constants.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_0       = 2'd0;
    localparam logic [1:0] ADDR_1       = 2'd1;
    localparam logic [1:0] ADDR_2       = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router. Defining
// ROUTER_FSM_SOFT_RESET_EN lets the addressed destination's soft reset abort a packet.
module router_fsm
    import router_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output state_t            state_dbg
);

    // Handshake: while busy is high the source holds its current byte; a byte
    // is taken by the datapath in every cycle where write_enb_reg is high.

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              hdr_ok;
    logic              empty_hdr;
    logic              empty_cur;
    logic              sr_cur;

    assign hdr_ok    = pkt_valid && (data_in != ADDR_INVALID);
    assign state_dbg = state_q;

    always_comb begin
        empty_hdr = 1'b0;
        empty_cur = 1'b0;
        sr_cur    = 1'b0;
        case (data_in)
            ADDR_0:  empty_hdr = fifo_empty_0;
            ADDR_1:  empty_hdr = fifo_empty_1;
            ADDR_2:  empty_hdr = fifo_empty_2;
            default: empty_hdr = 1'b0;
        endcase
        case (addr_q)
            ADDR_0:  begin empty_cur = fifo_empty_0; sr_cur = soft_reset_0; end
            ADDR_1:  begin empty_cur = fifo_empty_1; sr_cur = soft_reset_1; end
            ADDR_2:  begin empty_cur = fifo_empty_2; sr_cur = soft_reset_2; end
            default: begin empty_cur = 1'b0;         sr_cur = 1'b0;         end
        endcase
    end

`ifndef ROUTER_FSM_SOFT_RESET_EN
    logic soft_reset_unused;
    assign soft_reset_unused = sr_cur;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS:     if (hdr_ok) state_d = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:    if (empty_cur) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE:    if (!fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)           state_d = DECODE_ADDRESS;
                else if (low_packet_valid) state_d = LOAD_PARITY;
                else                       state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            state_d = DECODE_ADDRESS;
        endcase
`ifdef ROUTER_FSM_SOFT_RESET_EN
        // A read-timeout on the addressed destination abandons the packet.
        if (state_q != DECODE_ADDRESS && sr_cur) state_d = DECODE_ADDRESS;
`endif
    end

    // Outputs are registered from the next state, so they equal a decode of state_q.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= DECODE_ADDRESS;
            addr_q        <= '0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS && hdr_ok) addr_q <= data_in;
            detect_add    <= (state_d == DECODE_ADDRESS);
            lfd_state     <= (state_d == LOAD_FIRST_DATA);
            ld_state      <= (state_d == LOAD_DATA);
            laf_state     <= (state_d == LOAD_AFTER_FULL);
            full_state    <= (state_d == FIFO_FULL_STATE);
            write_enb_reg <= (state_d == LOAD_DATA) || (state_d == LOAD_AFTER_FULL) ||
                             (state_d == LOAD_PARITY);
            rst_int_reg   <= (state_d == CHECK_PARITY_ERROR);
            busy          <= (state_d != DECODE_ADDRESS) && (state_d != LOAD_DATA);
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed packet scenarios followed by
// random stimulus, all compared against a phase-name reference model.
module tb_router_fsm;
    import router_pkg::*;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    state_t     state_dbg;

    int         n_tests = 0;
    int         n_fail  = 0;

    string      phase = "DA";
    int         dest  = 0;
    bit         sr_en;

    router_fsm #(.ADDR_W(2)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done),
        .low_packet_valid(low_packet_valid), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit empty_of(int d);
        bit [2:0] e;
        e = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        return (d < 3) ? e[d] : 1'b0;
    endfunction

    function automatic bit sr_of(int d);
        bit [2:0] s;
        s = {soft_reset_2, soft_reset_1, soft_reset_0};
        return (d < 3) ? s[d] : 1'b0;
    endfunction

    // reference model: packet phase advanced once per rising edge
    task automatic model_edge();
        string nxt;
        nxt = phase;
        if (!resetn) begin
            phase = "DA";
            dest  = 0;
            return;
        end
        if (phase == "DA") begin
            if (pkt_valid && data_in != 2'd3) begin
                dest = int'(data_in);
                nxt  = empty_of(dest) ? "LFD" : "WTE";
            end
        end else if (phase == "WTE") begin
            if (empty_of(dest)) nxt = "LFD";
        end else if (phase == "LFD") nxt = "LD";
        else if (phase == "LD") begin
            if (fifo_full) nxt = "FFS";
            else if (!pkt_valid) nxt = "LP";
        end else if (phase == "FFS") begin
            if (!fifo_full) nxt = "LAF";
        end else if (phase == "LAF") begin
            nxt = parity_done ? "DA" : (low_packet_valid ? "LP" : "LD");
        end else if (phase == "LP") nxt = "CPE";
        else if (phase == "CPE") nxt = fifo_full ? "FFS" : "DA";
        if (sr_en && phase != "DA" && sr_of(dest)) nxt = "DA";
        phase = nxt;
    endtask

    // expected {detect,lfd,ld,laf,full,we,rst_int,busy} for the model phase
    function automatic logic [7:0] expected_outs(string p);
        logic we, bz;
        we = (p == "LD") || (p == "LAF") || (p == "LP");
        bz = !((p == "DA") || (p == "LD"));
        return {p == "DA", p == "LFD", p == "LD", p == "LAF", p == "FFS", we, p == "CPE", bz};
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s phase=%s observed=%b expected=%b", tag, phase, obs, exp);
        end
    endtask

    // driver: one clock edge, model update, then sample away from the edge
    task automatic tick(string tag);
        @(posedge clock);
        model_edge();
        #1;
        check(tag, {detect_add, lfd_state, ld_state, laf_state, full_state,
                    write_enb_reg, rst_int_reg, busy}, expected_outs(phase));
    endtask

    task automatic idle_inputs();
        pkt_valid = 0; data_in = 0; fifo_full = 0;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        parity_done = 0; low_packet_valid = 0;
    endtask

    initial begin
`ifdef ROUTER_FSM_SOFT_RESET_EN
        sr_en = 1'b1;
`else
        sr_en = 1'b0;
`endif
        idle_inputs();
        resetn = 0;
        @(negedge clock);

        // reset then idle
        tick("reset0");
        tick("reset1");
        resetn = 1;
        tick("idle0");
        tick("idle1");

        // header 1, empty FIFOs, four payload bytes then parity
        pkt_valid = 1; data_in = 2'd1;
        tick("hdr1");
        tick("lfd1");
        tick("pay1");
        tick("pay2");
        tick("pay3");
        pkt_valid = 0;
        tick("to_lp");
        tick("to_cpe");
        tick("to_da");

        // header 2 with destination not yet empty
        pkt_valid = 1; data_in = 2'd2; fifo_empty_2 = 0;
        for (int i = 0; i < 5; i++) tick("wte_hold");
        fifo_empty_2 = 1;
        tick("wte_to_lfd");
        tick("lfd_to_ld");

        // full stall in LD, then resume
        fifo_full = 1;
        for (int i = 0; i < 3; i++) tick("ffs_hold");
        fifo_full = 0;
        tick("to_laf");
        tick("laf_to_ld");
        pkt_valid = 0;
        tick("end_lp");
        tick("end_cpe");
        tick("end_da");

        // invalid address 3 is dropped
        pkt_valid = 1; data_in = 2'd3;
        for (int i = 0; i < 3; i++) tick("addr3");
        pkt_valid = 0;

        // soft reset while waiting on destination 0
        pkt_valid = 1; data_in = 2'd0; fifo_empty_0 = 0;
        tick("hdr0_wte");
        soft_reset_1 = 1;
        tick("sr_other");
        soft_reset_1 = 0; soft_reset_0 = 1;
        tick("sr_own");
        idle_inputs();
        resetn = 0;
        tick("sr_cleanup");
        resetn = 1;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            resetn           = ($urandom_range(0, 99) != 0);
            pkt_valid        = ($urandom_range(0, 9) < 7);
            data_in          = 2'($urandom_range(0, 3));
            fifo_full        = ($urandom_range(0, 9) < 3);
            fifo_empty_0     = ($urandom_range(0, 2) != 0);
            fifo_empty_1     = ($urandom_range(0, 2) != 0);
            fifo_empty_2     = ($urandom_range(0, 2) != 0);
            soft_reset_0     = ($urandom_range(0, 29) == 0);
            soft_reset_1     = ($urandom_range(0, 29) == 0);
            soft_reset_2     = ($urandom_range(0, 29) == 0);
            parity_done      = ($urandom_range(0, 3) == 0);
            low_packet_valid = ($urandom_range(0, 3) == 0);
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
